// File: rtl/tff_bank_seq_ctrl.sv
// Command sequencer for a bank of T flip-flops: accepts a toggle command,
// drives the bank's T inputs for a programmed number of pulses separated by
// programmable idle gaps, then checks the bank's Q against the predicted value.
module tff_bank_seq_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  input  logic [W-1:0]     q_in,
  output logic [W-1:0]     t,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

  state_t           state, state_n;
  logic [W-1:0]     mask_r, mask_n;
  logic [W-1:0]     exp_r, exp_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [GAP_W-1:0] gap_r, gap_n;
  logic [GAP_W-1:0] gcnt, gcnt_n;
  logic             done_n, err_n;
  logic             accept;

  assign cmd_ready = (state == IDLE) & ~abort;
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);
  // T is decoded purely from registered state, never from inputs.
  assign t         = (state == PULSE) ? mask_r : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath registers: command fields, counters, expected value, status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r <= '0;
      exp_r  <= '0;
      rem    <= '0;
      gap_r  <= '0;
      gcnt   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      mask_r <= mask_n;
      exp_r  <= exp_n;
      rem    <= rem_n;
      gap_r  <= gap_n;
      gcnt   <= gcnt_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_n = state;
    mask_n  = mask_r;
    exp_n   = exp_r;
    rem_n   = rem;
    gap_n   = gap_r;
    gcnt_n  = gcnt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          mask_n  = cmd_mask;
          rem_n   = cmd_count;
          gap_n   = cmd_gap;
          // An odd pulse count leaves the masked bits inverted.
          exp_n   = q_in ^ (cmd_count[0] ? cmd_mask : '0);
          state_n = (cmd_count != '0) ? PULSE : CHECK;
        end
      end
      PULSE: begin
        rem_n = rem - CNT_W'(1);
        if (abort) begin
          state_n = IDLE;
        end else if (rem == CNT_W'(1)) begin
          state_n = CHECK;
        end else if (gap_r != '0) begin
          gcnt_n  = gap_r;
          state_n = GAP;
        end else begin
          state_n = PULSE;
        end
      end
      GAP: begin
        gcnt_n = gcnt - GAP_W'(1);
        if (abort)                     state_n = IDLE;
        else if (gcnt == GAP_W'(1))    state_n = PULSE;
      end
      CHECK: begin
        state_n = IDLE;
        if (!abort) begin
          done_n = 1'b1;
          err_n  = (q_in != exp_r);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tff_bank_seq_ctrl.sv
// Directed testbench for tff_bank_seq_ctrl with a behavioural T flip-flop
// bank closing the loop from t back to q_in.
module tb_tff_bank_seq_ctrl;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [W-1:0]     cmd_mask = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [GAP_W-1:0] cmd_gap = '0;
  logic             abort = 1'b0;
  logic [W-1:0]     q_in;
  logic [W-1:0]     t;
  logic             busy, done, err;

  // Bank model
  logic [W-1:0] bank_q = '0;
  logic [W-1:0] bank_val = '0;
  logic         bank_load = 1'b0;
  logic         stuck = 1'b0;

  int errors = 0;
  int checks = 0;

  tff_bank_seq_ctrl #(.W(W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mask(cmd_mask), .cmd_count(cmd_count), .cmd_gap(cmd_gap),
    .abort(abort), .q_in(q_in), .t(t), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_val;
    else           bank_q <= bank_q ^ t;
  end

  // Bit 1 can be forced low to model a stuck flip-flop.
  assign q_in = stuck ? (bank_q & 4'b1101) : bank_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] m, input logic [CNT_W-1:0] c, input logic [GAP_W-1:0] g);
    cmd_valid = 1'b1;
    cmd_mask  = m;
    cmd_count = c;
    cmd_gap   = g;
  endtask

  initial begin
    // Reset / idle
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_t", 32'(t), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    tick();

    // Abort in IDLE blocks acceptance
    abort = 1'b1;
    send(4'b0001, 8'd1, 4'd0);
    #1;
    check("idle_abort_ready", 32'(cmd_ready), 32'h0);
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'h0);

    // Odd count, no gap: bank 0000, mask 0101, count 3
    send(4'b0101, 8'd3, 4'd0);
    #1;
    check("t1_ready", 32'(cmd_ready), 32'h1);
    tick(); cmd_valid = 1'b0;                       // cycle 1
    check("t1_c1_t", 32'(t), 32'h5);
    check("t1_c1_busy", 32'(busy), 32'h1);
    tick(); check("t1_c2_t", 32'(t), 32'h5);        // cycle 2
    tick(); check("t1_c3_t", 32'(t), 32'h5);        // cycle 3
    tick();                                         // cycle 4 CHECK
    check("t1_c4_t", 32'(t), 32'h0);
    check("t1_c4_busy", 32'(busy), 32'h1);
    check("t1_c4_q", 32'(q_in), 32'h5);
    check("t1_c4_done", 32'(done), 32'h0);
    tick();                                         // cycle 5
    check("t1_c5_done", 32'(done), 32'h1);
    check("t1_c5_err", 32'(err), 32'h0);
    check("t1_c5_busy", 32'(busy), 32'h0);
    tick();
    check("t1_c6_done", 32'(done), 32'h0);

    // Even count with gap: bank 1111, mask 1001, count 2, gap 2
    bank_val = 4'b1111; bank_load = 1'b1;
    tick(); bank_load = 1'b0;
    send(4'b1001, 8'd2, 4'd2);
    tick(); cmd_valid = 1'b0;                       // cycle 1
    check("t2_c1_t", 32'(t), 32'h9);
    tick(); check("t2_c2_t", 32'(t), 32'h0);
    tick(); check("t2_c3_t", 32'(t), 32'h0);
    check("t2_c3_busy", 32'(busy), 32'h1);
    tick(); check("t2_c4_t", 32'(t), 32'h9);
    tick(); check("t2_c5_t", 32'(t), 32'h0);        // CHECK
    check("t2_c5_done", 32'(done), 32'h0);
    tick();                                         // cycle 6
    check("t2_c6_done", 32'(done), 32'h1);
    check("t2_c6_err", 32'(err), 32'h0);
    check("t2_c6_q", 32'(q_in), 32'hF);

    // Mismatch: bank 1111, bit1 stuck low -> q_in 1101, mask 0011, count 1
    stuck = 1'b1;
    send(4'b0011, 8'd1, 4'd0);
    tick(); cmd_valid = 1'b0;                       // cycle 1 PULSE
    check("t3_c1_t", 32'(t), 32'h3);
    tick();                                         // cycle 2 CHECK
    tick();                                         // cycle 3
    check("t3_c3_done", 32'(done), 32'h1);
    check("t3_c3_err", 32'(err), 32'h1);
    tick();
    check("t3_c4_done", 32'(done), 32'h0);
    check("t3_c4_err", 32'(err), 32'h0);
    stuck = 1'b0;                                   // bank now 1100

    // Abort mid-run: mask 0001, count 10, gap 1, abort at cycle 4 (GAP)
    send(4'b0001, 8'd10, 4'd1);
    tick(); cmd_valid = 1'b0;                       // cycle 1
    check("t4_c1_t", 32'(t), 32'h1);
    tick(); check("t4_c2_t", 32'(t), 32'h0);
    tick(); check("t4_c3_t", 32'(t), 32'h1);
    tick();                                         // cycle 4
    abort = 1'b1;
    #1;
    check("t4_c4_ready", 32'(cmd_ready), 32'h0);
    tick(); abort = 1'b0;                           // cycle 5
    check("t4_c5_t", 32'(t), 32'h0);
    check("t4_c5_busy", 32'(busy), 32'h0);
    check("t4_c5_done", 32'(done), 32'h0);
    check("t4_c5_q", 32'(q_in), 32'hC);
    send(4'b0001, 8'd1, 4'd0);
    #1;
    check("t4_c5_ready", 32'(cmd_ready), 32'h1);
    tick(); cmd_valid = 1'b0;                       // cycle 6
    check("t4_c6_t", 32'(t), 32'h1);
    check("t4_c6_done", 32'(done), 32'h0);
    tick();                                         // cycle 7 CHECK
    check("t4_c7_done", 32'(done), 32'h0);
    tick();                                         // cycle 8
    check("t4_c8_done", 32'(done), 32'h1);
    check("t4_c8_err", 32'(err), 32'h0);
    tick();                                         // bank 1101

    // count=0 then back-to-back command held valid
    send(4'b1111, 8'd0, 4'd0);
    tick();                                         // cycle 1 CHECK
    send(4'b0010, 8'd1, 4'd0);
    #1;
    check("t5_c1_t", 32'(t), 32'h0);
    check("t5_c1_ready", 32'(cmd_ready), 32'h0);
    check("t5_c1_busy", 32'(busy), 32'h1);
    tick();                                         // cycle 2
    check("t5_c2_done", 32'(done), 32'h1);
    check("t5_c2_err", 32'(err), 32'h0);
    check("t5_c2_ready", 32'(cmd_ready), 32'h1);
    tick(); cmd_valid = 1'b0;                       // cycle 3
    check("t5_c3_t", 32'(t), 32'h2);
    check("t5_c3_done", 32'(done), 32'h0);
    tick();                                         // cycle 4 CHECK
    tick();                                         // cycle 5
    check("t5_c5_done", 32'(done), 32'h1);
    check("t5_c5_err", 32'(err), 32'h0);
    check("t5_c5_q", 32'(q_in), 32'hF);
    tick();

    // Reset mid-command suppresses completion
    send(4'b0001, 8'd5, 4'd0);
    tick(); cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_t", 32'(t), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6_no_done", 32'(done), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
